// File: rtl/bt_radio_ctrl_pkg.sv
// Shared types and constants for the radio control stage.
// Build option: BT_RADIO_CTRL_RAMP_EN adds the PA ramp-down state.
package bt_radio_ctrl_pkg;

  localparam int MAX_FK_DEF = 78;
  localparam int CNT_W      = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LOCKED,
    ST_TX,
    ST_RX
`ifdef BT_RADIO_CTRL_RAMP_EN
    , ST_RAMPDN
`endif
  } state_t;

endpackage

// File: rtl/bt_radio_ctrl_if.sv
// Link-controller <-> radio-control signal bundle.
// The master side is the link controller; the slave side is bt_radio_ctrl.
interface bt_radio_ctrl_if;
  import bt_radio_ctrl_pkg::*;

  logic             p_1us;
  logic [CNT_W-1:0] regi_pllsetuptime;
  logic             loadfreq_p;
  logic [6:0]       lc_fk;
  logic             txen;
  logic             rxen;
  logic             txbitin;
  logic             rxbitin;

  logic [6:0]       synth_fk;
  logic             synth_load_p;
  logic             pll_lock;
  logic             pa_en;
  logic             lna_en;
  logic             txbitout;
  logic             rxbitout;
  logic             ctrl_err;

  modport master (
    output p_1us, regi_pllsetuptime, loadfreq_p, lc_fk, txen, rxen, txbitin, rxbitin,
    input  synth_fk, synth_load_p, pll_lock, pa_en, lna_en, txbitout, rxbitout, ctrl_err
  );

  modport slave (
    input  p_1us, regi_pllsetuptime, loadfreq_p, lc_fk, txen, rxen, txbitin, rxbitin,
    output synth_fk, synth_load_p, pll_lock, pa_en, lna_en, txbitout, rxbitout, ctrl_err
  );

endinterface

// File: rtl/bt_radio_us_timer.sv
// Microsecond down-counter shared by PLL settle and PA ramp-down.
// o_done is combinational so the FSM can act on the same edge as the final strobe.
module bt_radio_us_timer
  import bt_radio_ctrl_pkg::*;
(
  input  logic             clk_6M,
  input  logic             rstz,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_tick,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // A load wins over a coincident strobe, so that strobe is never counted.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Expired already (zero load) or expiring on this strobe.
  assign o_done = !i_load && ((r_cnt == '0) || ((r_cnt == CNT_W'(1)) && i_tick));

endmodule

// File: rtl/bt_radio_ctrl.sv
// Radio control stage: synthesiser load, PLL settle timing and PA/LNA/bit gating.
// Build option: BT_RADIO_CTRL_RAMP_EN holds the PA on for RAMP_US us after each TX window.
module bt_radio_ctrl
  import bt_radio_ctrl_pkg::*;
#(
  parameter int MAX_FK  = MAX_FK_DEF,
  parameter int RAMP_US = 3
) (
  input  logic            clk_6M,
  input  logic            rstz,
  bt_radio_ctrl_if.slave  bus
);

  localparam logic [6:0] LP_MAX_FK = 7'(MAX_FK);

  state_t           r_state;
  logic [6:0]       r_synth_fk;
  logic             r_synth_load_p;
  logic             r_pll_lock;
  logic             r_pa_en;
  logic             r_lna_en;
  logic             r_txbitout;
  logic             r_rxbitout;
  logic             r_ctrl_err;

  logic             w_load_ok;
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_done;

  assign w_load_ok = bus.loadfreq_p && (bus.lc_fk <= LP_MAX_FK);

`ifdef BT_RADIO_CTRL_RAMP_EN
  assign w_tmr_load = w_load_ok || ((r_state == ST_TX) && !bus.txen);
`else
  assign w_tmr_load = w_load_ok;
`endif
  assign w_tmr_val = w_load_ok ? bus.regi_pllsetuptime : CNT_W'(RAMP_US);

  bt_radio_us_timer u_timer (
    .clk_6M     (clk_6M),
    .rstz       (rstz),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_tick     (bus.p_1us),
    .o_done     (w_tmr_done)
  );

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      r_state        <= ST_IDLE;
      r_synth_fk     <= '0;
      r_synth_load_p <= 1'b0;
      r_pll_lock     <= 1'b0;
      r_pa_en        <= 1'b0;
      r_lna_en       <= 1'b0;
      r_txbitout     <= 1'b0;
      r_rxbitout     <= 1'b0;
      r_ctrl_err     <= 1'b0;
    end else begin
      r_synth_load_p <= 1'b0;
      if (w_load_ok) begin
        // Legal retune from any state; an open TX/RX window is aborted.
        r_synth_fk     <= bus.lc_fk;
        r_synth_load_p <= 1'b1;
        r_pll_lock     <= 1'b0;
        r_pa_en        <= 1'b0;
        r_lna_en       <= 1'b0;
        r_txbitout     <= 1'b0;
        r_rxbitout     <= 1'b0;
        r_state        <= ST_SETTLE;
        if ((r_state == ST_TX) || (r_state == ST_RX)) begin
          r_ctrl_err <= 1'b1;
        end
      end else begin
        if (bus.loadfreq_p) begin
          r_ctrl_err <= 1'b1;
        end
        case (r_state)
          ST_IDLE, ST_SETTLE: begin
            if (bus.txen || bus.rxen) begin
              r_ctrl_err <= 1'b1;
            end
            if ((r_state == ST_SETTLE) && w_tmr_done) begin
              r_pll_lock <= 1'b1;
              r_state    <= ST_LOCKED;
            end
          end
          ST_LOCKED: begin
            if (bus.txen) begin
              r_pa_en    <= 1'b1;
              r_txbitout <= bus.txbitin;
              r_state    <= ST_TX;
              if (bus.rxen) begin
                r_ctrl_err <= 1'b1;
              end
            end else if (bus.rxen) begin
              r_lna_en   <= 1'b1;
              r_rxbitout <= bus.rxbitin;
              r_state    <= ST_RX;
            end
          end
          ST_TX: begin
            if (bus.txen) begin
              r_txbitout <= bus.txbitin;
            end else begin
              r_txbitout <= 1'b0;
`ifdef BT_RADIO_CTRL_RAMP_EN
              r_state    <= ST_RAMPDN;
`else
              r_pa_en    <= 1'b0;
              r_state    <= ST_LOCKED;
`endif
            end
          end
          ST_RX: begin
            if (bus.rxen) begin
              r_rxbitout <= bus.rxbitin;
            end else begin
              r_rxbitout <= 1'b0;
              r_lna_en   <= 1'b0;
              r_state    <= ST_LOCKED;
            end
          end
`ifdef BT_RADIO_CTRL_RAMP_EN
          // PA stays on with a silent bit stream; rxen waits for LOCKED.
          ST_RAMPDN: begin
            r_txbitout <= 1'b0;
            if (w_tmr_done) begin
              r_pa_en <= 1'b0;
              r_state <= ST_LOCKED;
            end
          end
`endif
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.synth_fk     = r_synth_fk;
  assign bus.synth_load_p = r_synth_load_p;
  assign bus.pll_lock     = r_pll_lock;
  assign bus.pa_en        = r_pa_en;
  assign bus.lna_en       = r_lna_en;
  assign bus.txbitout     = r_txbitout;
  assign bus.rxbitout     = r_rxbitout;
  assign bus.ctrl_err     = r_ctrl_err;

endmodule
